// File: rtl/vga_board_adapter_if.sv
// vga_board_adapter_if: core-side pixel bus and board-side VGA/status outputs of the adapter.
interface vga_board_adapter_if #(parameter int COLOR_BITS = 2);
  logic [7:0] uo_in;
  logic core_rst_n;
  logic vga_hsync;
  logic vga_vsync;
  logic [COLOR_BITS-1:0] vga_r;
  logic [COLOR_BITS-1:0] vga_g;
  logic [COLOR_BITS-1:0] vga_b;
  logic led_status;
  modport master (
    input uo_in,
    output core_rst_n, vga_hsync, vga_vsync, vga_r, vga_g, vga_b, led_status
  );
  modport slave (
    output uo_in,
    input core_rst_n, vga_hsync, vga_vsync, vga_r, vga_g, vga_b, led_status
  );
endinterface

// File: rtl/vga_board_adapter.sv
// vga_board_adapter: lock qualification, button debounce, core reset FSM, VGA unpack/blank and status LED.
module vga_board_adapter #(
  parameter int COLOR_BITS = 2,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int BLINK_DIV_LOG2 = 23,
  parameter int FRAME_DIV = 30
) (
  input logic clk,
  input logic rst,
  input logic pll_locked,
  input logic btn_n,
  vga_board_adapter_if.master bus
);
  localparam int LW = LOCK_STABLE_CYCLES > 1 ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int FW = FRAME_DIV > 1 ? $clog2(FRAME_DIV) : 1;
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FW-1:0] FRAME_MAX = FW'(FRAME_DIV - 1);
  localparam logic SYNC_OFF = SYNC_ACTIVE_LOW != 0;
  typedef enum logic [1:0] {WAIT_LOCK, STABILIZE, HOLD, RUN} state_t;
  state_t state;
  logic [1:0] lock_sync, btn_sync;
  logic lock_s, btn_s, btn_db, run, core_rst_n;
  logic [LW-1:0] lock_cnt;
  logic [DW-1:0] db_cnt;
  logic [FW-1:0] frame_cnt;
  logic [BLINK_DIV_LOG2-1:0] blink;
  logic hsync, vsync, hs_n, vs_n, vs_rise, led;
  logic [COLOR_BITS-1:0] r, g, b;
  function automatic logic [COLOR_BITS-1:0] expand(input logic [1:0] c);
    expand = '0;
    for (int i = 0; i < COLOR_BITS; i++) expand[COLOR_BITS-1-i] = i[0] ? c[0] : c[1];
  endfunction
  assign lock_s = lock_sync[1];
  assign btn_s = btn_sync[1];
  assign run = state == RUN;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lock_sync <= 2'b00;
      btn_sync <= 2'b11;
    end else begin
      lock_sync <= {lock_sync[0], pll_locked};
      btn_sync <= {btn_sync[0], btn_n};
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      db_cnt <= '0;
      btn_db <= 1'b1;
    end else if (btn_s == btn_db) db_cnt <= '0;
    else if (db_cnt == DB_MAX) begin
      btn_db <= btn_s;
      db_cnt <= '0;
    end else db_cnt <= db_cnt + 1'b1;
  // Lock loss is tested first in every state so it always beats button events.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= WAIT_LOCK;
      lock_cnt <= '0;
      core_rst_n <= 1'b0;
    end else
      case (state)
        WAIT_LOCK: begin
          lock_cnt <= '0;
          if (lock_s) state <= STABILIZE;
        end
        STABILIZE:
          if (!lock_s) state <= WAIT_LOCK;
          else if (lock_cnt == LOCK_MAX) begin
            state <= btn_db ? RUN : HOLD;
            core_rst_n <= btn_db;
          end else lock_cnt <= lock_cnt + 1'b1;
        HOLD:
          if (!lock_s) state <= WAIT_LOCK;
          else if (btn_db) begin
            state <= RUN;
            core_rst_n <= 1'b1;
          end
        default: begin
          if (!lock_s) state <= WAIT_LOCK;
          else if (!btn_db) state <= HOLD;
          core_rst_n <= lock_s && btn_db;
        end
      endcase
  assign hs_n = run ? bus.uo_in[7] : SYNC_OFF;
  assign vs_n = run ? bus.uo_in[3] : SYNC_OFF;
  // Detect the vsync edge on the value being registered so the LED moves on the same edge as vga_vsync.
  assign vs_rise = run && vsync == SYNC_OFF && vs_n != SYNC_OFF;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hsync <= SYNC_OFF;
      vsync <= SYNC_OFF;
      r <= '0;
      g <= '0;
      b <= '0;
    end else begin
      hsync <= hs_n;
      vsync <= vs_n;
      r <= run ? expand({bus.uo_in[0], bus.uo_in[4]}) : '0;
      g <= run ? expand({bus.uo_in[1], bus.uo_in[5]}) : '0;
      b <= run ? expand({bus.uo_in[2], bus.uo_in[6]}) : '0;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      blink <= '0;
      frame_cnt <= '0;
      led <= 1'b0;
    end else begin
      blink <= blink + 1'b1;
      frame_cnt <= !run ? '0 : !vs_rise ? frame_cnt : frame_cnt == FRAME_MAX ? '0 : frame_cnt + 1'b1;
      led <= state == WAIT_LOCK ? 1'b0 : run ? led ^ (vs_rise && frame_cnt == FRAME_MAX) : led ^ (&blink);
    end
  assign bus.core_rst_n = core_rst_n;
  assign bus.vga_hsync = hsync;
  assign bus.vga_vsync = vsync;
  assign bus.vga_r = r;
  assign bus.vga_g = g;
  assign bus.vga_b = b;
  assign bus.led_status = led;
endmodule
